imem_arbiter: RTL
=================

# imem_arbiter

Two-requester arbiter and sequencer for the single-port, asynchronous-read instruction memory. It sits between the IF stage's fetch port, the debug/loader read port and the instruction ROM. Each cycle it selects at most one requester and drives the ROM's chip-enable and address. It returns the fetched word to the winner as a registered, one-cycle response. It also provides starvation protection, a debug lock for burst reads, pipeline-flush masking and a misaligned-address error.

## Interface
Parameters:
- DBG_MAX_WAIT, default 4: consecutive denied cycles after which a pending debug request beats IF (range 1..15).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset (`RstEnable`)
- if_req  in  1  IF stage requests a fetch this cycle
- if_addr  in  32 (`InstAddrBus`)  IF byte address
- if_gnt  out  1  IF request accepted this cycle (combinational)
- if_rvalid  out  1  IF response valid (registered)
- if_rdata  out  32 (`InstBus`)  IF instruction word
- if_rerr  out  1  IF response was misaligned
- dbg_req  in  1  debug read request
- dbg_addr  in  32  debug byte address
- dbg_lock  in  1  hold exclusive ownership for a debug burst
- dbg_gnt  out  1  debug request accepted this cycle (combinational)
- dbg_rvalid  out  1  debug response valid (registered)
- dbg_rdata  out  32  debug data word
- dbg_rerr  out  1  debug response was misaligned
- flush  in  1  pipeline flush from the control unit
- mem_ce  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- mem_addr  out  32  ROM byte address
- mem_inst  in  32  ROM read data, combinational from mem_addr

## Operation
- **FSM states.** IDLE and DBG_LOCK. Reset enters IDLE.
- **IDLE arbitration.** IF has fixed priority, except that debug wins when wait_cnt == DBG_MAX_WAIT.
  - Only one of if_gnt or dbg_gnt is ever high.
  - A grant requires the requester's req to be high.
- **Transition to DBG_LOCK.** On a debug grant with dbg_lock=1, go to DBG_LOCK.
- **DBG_LOCK behaviour.**
  - if_gnt is forced 0.
  - dbg_gnt equals dbg_req.
  - The FSM returns to IDLE at the end of the first cycle in which dbg_lock=0. The debug request in that cycle is still granted.
- **wait_cnt (4 bits).**
  - Increments on each cycle with dbg_req=1 and dbg_gnt=0, saturating at DBG_MAX_WAIT.
  - Clears on a debug grant or when dbg_req=0.
- **Memory drive.**
  - With no grant: mem_ce=`ChipDisable` and mem_addr=0.
  - With a grant: mem_addr is the winner's address, and mem_ce=`ChipEnable` only if addr[1:0]==2'b00.
- **Misaligned access.** The request is still granted and the ROM is not enabled. The response returns rdata=`ZEROWORD` with rerr=1.
- **Flush.**
  - While flush=1, if_gnt is forced 0 in that cycle; debug may win instead.
  - if_rvalid is masked to 0 in that same cycle, discarding a response already in flight.
  - Flush has no effect on the debug path.
- **Response register.** At the clock edge ending a grant cycle, capture the owner, mem_inst (or 0 if misaligned) and the error flag. In the next cycle assert exactly one of if_rvalid or dbg_rvalid together with its rdata/rerr.
  - rvalid is a single-cycle pulse. rdata and rerr hold their last value when rvalid=0.

## Timing
- **Latency.** A request granted in cycle N responds in cycle N+1. Back-to-back grants give one response per cycle, for full throughput.
- **Address timing.** mem_addr and mem_ce are combinational from the current-cycle request; no extra cycle is added.
- **Reset values.** The following are 0:
  - if_rvalid, dbg_rvalid, if_rerr, dbg_rerr
  - if_rdata, dbg_rdata
  - wait_cnt
  - state=IDLE
- **Combinational outputs during reset.** if_gnt, dbg_gnt and mem_ce are 0 and mem_addr is 0 while rst=1.
- **Reset mid-operation.** A response pending from the cycle before reset is dropped, with no rvalid in the reset cycle or after it. A lock held at reset is released.
- **Simultaneous requests.**
  - Both requesting with wait_cnt<DBG_MAX_WAIT: IF wins.
  - Both requesting with wait_cnt==DBG_MAX_WAIT: debug wins.
  - Both requesting with flush=1: debug wins.
- **Starvation bound.** While if_req is held high, a continuously pending debug request is granted at latest in the (DBG_MAX_WAIT+1)th cycle.

## Test plan
- **Single IF fetch.** if_req with if_addr=0x0000_0008, ROM word[2]=0x3401_1100 -> if_gnt=1, mem_ce=1, mem_addr=0x8 in N; if_rvalid=1, if_rdata=0x3401_1100, if_rerr=0 in N+1.
- **Starvation.** if_req and dbg_req held high, DBG_MAX_WAIT=4 -> IF granted in cycles 0-3, debug granted in cycle 4, IF again in cycle 5; dbg_rvalid in cycle 5.
- **Debug lock burst.** dbg_lock=1 for 3 cycles with dbg_addr 0x0,0x4,0x8 and if_req high -> if_gnt=0 throughout; three dbg_rvalid pulses with words 0,1,2; IF granted on the cycle after dbg_lock falls.
- **Flush.** IF granted in N, flush=1 in N+1 with if_req=1 -> if_rvalid=0 in N+1, if_gnt=0 in N+1; a grant in N+2 responds normally in N+3.
- **Misaligned.** dbg_addr=0x0000_0006 -> dbg_gnt=1, mem_ce=0; next cycle dbg_rvalid=1, dbg_rdata=0, dbg_rerr=1.
- **Reset mid-op.** Grant in N, rst=1 in N+1 while locked -> no rvalid in N+1, all outputs 0, state IDLE; an IF request after reset is granted immediately.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, debug, flush and ROM signals around the instruction-memory arbiter.
// The arbiter takes the slave view; the requesters and the ROM together take the master view.
interface imem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_rerr;

  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_lock;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_rerr;

  logic        flush;

  logic        mem_ce;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, dbg_lock, flush, mem_inst,
    input  if_gnt, if_rvalid, if_rdata, if_rerr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr,
    input  mem_ce, mem_addr
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, dbg_lock, flush, mem_inst,
    output if_gnt, if_rvalid, if_rdata, if_rerr,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_rerr,
    output mem_ce, mem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbiter/sequencer for the asynchronous-read instruction ROM: IF vs debug selection,
// starvation guard, debug burst lock, flush masking and a registered one-cycle response.
module imem_arbiter #(
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] ZEROWORD     = 32'h0000_0000;
  localparam logic [3:0]  MAX_WAIT     = 4'(DBG_MAX_WAIT);

  typedef enum logic {
    IDLE     = 1'b0,
    DBG_LOCK = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;

  logic        w_if_gnt;
  logic        w_dbg_gnt;
  logic        w_any_gnt;
  logic [31:0] w_sel_addr;
  logic        w_misaligned;
  logic [31:0] w_rsp_data;

  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_if_rerr;
  logic        r_dbg_rvalid;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_rerr;

  // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_dbg_gnt && bus.dbg_lock) w_state_nxt = DBG_LOCK;
      DBG_LOCK: if (!bus.dbg_lock)             w_state_nxt = IDLE;
      default:                                 w_state_nxt = IDLE;
    endcase
  end

  // Grant decode: IF has priority in IDLE unless flushed or debug has waited its limit.
  always_comb begin
    w_if_gnt  = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          w_if_gnt  = bus.if_req && !bus.flush &&
                      !(bus.dbg_req && (r_wait_cnt == MAX_WAIT));
          w_dbg_gnt = bus.dbg_req && !w_if_gnt;
        end
        DBG_LOCK: w_dbg_gnt = bus.dbg_req;
        default: begin
          w_if_gnt  = 1'b0;
          w_dbg_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_any_gnt    = w_if_gnt || w_dbg_gnt;
    w_sel_addr   = w_if_gnt ? bus.if_addr : (w_dbg_gnt ? bus.dbg_addr : ZEROWORD);
    w_misaligned = w_any_gnt && (w_sel_addr[1:0] != 2'b00);
    w_rsp_data   = w_misaligned ? ZEROWORD : bus.mem_inst;
  end

  assign bus.mem_addr = w_sel_addr;
  assign bus.mem_ce   = (w_any_gnt && !w_misaligned) ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.if_gnt   = w_if_gnt;
  assign bus.dbg_gnt  = w_dbg_gnt;

  always_ff @(posedge clk) begin
    if (rst || !bus.dbg_req || w_dbg_gnt) r_wait_cnt <= 4'd0;
    else if (r_wait_cnt != MAX_WAIT)      r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  // NOTE: the response data registers are reset too, because their value is visible on the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= ZEROWORD;
      r_if_rerr    <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= ZEROWORD;
      r_dbg_rerr   <= 1'b0;
    end else begin
      r_if_rvalid  <= w_if_gnt;
      r_dbg_rvalid <= w_dbg_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= w_rsp_data;
        r_if_rerr  <= w_misaligned;
      end
      if (w_dbg_gnt) begin
        r_dbg_rdata <= w_rsp_data;
        r_dbg_rerr  <= w_misaligned;
      end
    end
  end

  // A response in flight is dropped by a flush (IF only) or by reset in the current cycle.
  assign bus.if_rvalid  = r_if_rvalid && !bus.flush && !rst;
  assign bus.if_rdata   = rst ? ZEROWORD : r_if_rdata;
  assign bus.if_rerr    = r_if_rerr && !rst;
  assign bus.dbg_rvalid = r_dbg_rvalid && !rst;
  assign bus.dbg_rdata  = rst ? ZEROWORD : r_dbg_rdata;
  assign bus.dbg_rerr   = r_dbg_rerr && !rst;

endmodule
